// File: rtl/regf_pkg.sv
// regf_pkg: shared definitions for the register-file bus controller.
//   regf_state_e    controller state encoding
//   REGF_WIDTH      default data width (register-file word width)
//   REGF_AWIDTH     default address width (32 locations)
//   CS_IDLE/OE_IDLE/WS_IDLE  strobe levels while no transfer is in flight
//   regf_cnt_width  width needed by the wait-state counter
package regf_pkg;

  localparam int unsigned REGF_WIDTH  = 8;
  localparam int unsigned REGF_AWIDTH = 5;

  localparam logic CS_IDLE = 1'b1;
  localparam logic OE_IDLE = 1'b0;
  localparam logic WS_IDLE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_ACCESS,
    R_DONE,
    V_ACCESS,
    V_DONE
  } regf_state_e;

  // Counter only ever holds values up to max(a,b)-1.
  function automatic int unsigned regf_cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/regf_wait_cnt.sv
// regf_wait_cnt: loadable down-counter used to time setup and strobe phases.
//   clk       rising-edge clock
//   rst       synchronous active-high reset (count -> 0)
//   load      load load_val this cycle (takes priority over counting)
//   load_val  remaining extra cycles for the phase being entered
//   expired   count has reached zero; the current phase ends at this edge
// The counter parks at zero instead of wrapping.
module regf_wait_cnt
  import regf_pkg::*;
#(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/regf_bus_ctrl.sv
// regf_bus_ctrl: synchronous front-end for a 32x8 asynchronous register file.
// Converts single-cycle host read/write requests (ready/valid, DONE pulse)
// into the file's CS/OE/WS/ADDR strobes and owns the bidirectional DATA bus.
//   CLK       rising-edge clock
//   RST       synchronous active-high reset
//   REQ       host request valid; accepted on an edge with REQ && READY
//   READY     controller idle and able to accept
//   WR        1 = write, 0 = read (sampled at accept)
//   REQ_ADDR  target address (sampled at accept)
//   WR_DATA   write data (sampled at accept)
//   RD_DATA   read result, valid with DONE, held until the next read
//   DONE      one-cycle completion pulse
//   VERR      write-verify mismatch, pulses with DONE
//   DATA      register-file data bus (driven on writes only)
//   ADDR      register-file address
//   CS        chip select, active low
//   OE        output enable, high = file drives DATA
//   WS        write strobe, file captures on its rising edge
// Optional feature: define REGF_WRITE_VERIFY_EN to read back every write and
// flag a mismatch on VERR; otherwise VERR stays 0.
module regf_bus_ctrl
  import regf_pkg::*;
#(
  parameter int unsigned WIDTH      = REGF_WIDTH,
  parameter int unsigned AWIDTH     = REGF_AWIDTH,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  output logic              READY,
  input  logic              WR,
  input  logic [AWIDTH-1:0] REQ_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  output logic [WIDTH-1:0]  RD_DATA,
  output logic              DONE,
  output logic              VERR,
  inout  wire logic [WIDTH-1:0] DATA,
  output logic [AWIDTH-1:0] ADDR,
  output logic              CS,
  output logic              OE,
  output logic              WS
);

  localparam int unsigned CW = regf_cnt_width(SETUP_CYC, STROBE_CYC);
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYC - 1);

  regf_state_e      state;
  logic [WIDTH-1:0] wdata_q;
  logic             drive_en;
  logic             cnt_load;
  logic [CW-1:0]    cnt_val;
  logic             cnt_expired;

  // Bus is only ever driven from a registered enable.
  assign DATA = drive_en ? wdata_q : 'z;

  // Only phases longer than one cycle need a load; every other state is
  // entered with the counter already parked at zero.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (REQ) begin
          cnt_load = 1'b1;
          cnt_val  = SETUP_LOAD;
        end
      end
      W_SETUP: begin
        if (cnt_expired) begin
          cnt_load = 1'b1;
          cnt_val  = STROBE_LOAD;
        end
      end
`ifdef REGF_WRITE_VERIFY_EN
      W_HOLD: begin
        cnt_load = 1'b1;
        cnt_val  = SETUP_LOAD;
      end
`endif
      default: ;
    endcase
  end

  regf_wait_cnt #(
    .CW (CW)
  ) u_wait_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expired  (cnt_expired)
  );

  // Outputs are set on the edge that enters each state, so every strobe is
  // a flop output and matches the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      READY    <= 1'b1;
      DONE     <= 1'b0;
      VERR     <= 1'b0;
      RD_DATA  <= '0;
      CS       <= CS_IDLE;
      OE       <= OE_IDLE;
      WS       <= WS_IDLE;
      ADDR     <= '0;
      drive_en <= 1'b0;
      wdata_q  <= '0;
    end else begin
      DONE <= 1'b0;
      VERR <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            READY   <= 1'b0;
            ADDR    <= REQ_ADDR;
            wdata_q <= WR_DATA;
            CS      <= ~CS_IDLE;
            if (WR) begin
              state    <= W_SETUP;
              drive_en <= 1'b1;
            end else begin
              state <= R_ACCESS;
              OE    <= ~OE_IDLE;
            end
          end
        end
        W_SETUP: begin
          if (cnt_expired) begin
            state <= W_STROBE;
            WS    <= ~WS_IDLE;
          end
        end
        W_STROBE: begin
          if (cnt_expired) begin
            state <= W_HOLD;
            WS    <= WS_IDLE;
`ifndef REGF_WRITE_VERIFY_EN
            DONE  <= 1'b1;
`endif
          end
        end
        W_HOLD: begin
          drive_en <= 1'b0;
`ifdef REGF_WRITE_VERIFY_EN
          state <= V_ACCESS;
          OE    <= ~OE_IDLE;
`else
          state <= IDLE;
          CS    <= CS_IDLE;
          READY <= 1'b1;
`endif
        end
        R_ACCESS: begin
          if (cnt_expired) begin
            state   <= R_DONE;
            RD_DATA <= DATA;
            CS      <= CS_IDLE;
            OE      <= OE_IDLE;
            DONE    <= 1'b1;
          end
        end
        R_DONE: begin
          state <= IDLE;
          READY <= 1'b1;
        end
`ifdef REGF_WRITE_VERIFY_EN
        V_ACCESS: begin
          if (cnt_expired) begin
            state   <= V_DONE;
            RD_DATA <= DATA;
            VERR    <= (DATA != wdata_q);
            CS      <= CS_IDLE;
            OE      <= OE_IDLE;
            DONE    <= 1'b1;
          end
        end
        V_DONE: begin
          state <= IDLE;
          READY <= 1'b1;
        end
`endif
        default: begin
          state    <= IDLE;
          READY    <= 1'b1;
          CS       <= CS_IDLE;
          OE       <= OE_IDLE;
          WS       <= WS_IDLE;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
